rmt_checkpoint_manager: RTL and testbench

//  Owns the branch checkpoint store for the register mapping table (RMT). Allocates checkpoint

---
 rtl/rmt_checkpoint_manager.sv | 156 +++++++++++++++
 tb/tb_rmt_checkpoint_manager.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmt_checkpoint_manager.sv
// Branch checkpoint store for the rename map table: in-order slot allocation, snapshot capture,
// in-order retirement of resolved branches, and squash plus one-cycle recall on mispredict.
module rmt_checkpoint_manager #(
  parameter int unsigned NumPr   = 64,
  parameter int unsigned NumCkpt = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                ext_stall_i,
  input  logic [1:0]                          br_valid_i,
  output logic [1:0]                          if_checkpoint_o,
  output logic [$clog2(NumCkpt)-1:0]          ckpt_tag_o,
  output logic                                ckpt_stall_o,
  input  logic [32*$clog2(NumPr)-1:0]         checkpointed_rmt_i,
  input  logic                                res_valid_i,
  input  logic [$clog2(NumCkpt)-1:0]          res_tag_i,
  input  logic                                res_mispredict_i,
  output logic                                if_recall_o,
  output logic [32*$clog2(NumPr)-1:0]         recalled_rmt_o,
  output logic [NumCkpt-1:0]                  squash_mask_o,
  output logic                                full_o,
  output logic [$clog2(NumCkpt):0]            free_count_o
);

  localparam int unsigned Prw  = $clog2(NumPr);
  localparam int unsigned TagW = $clog2(NumCkpt);
  localparam int unsigned CntW = TagW + 1;
  localparam int unsigned SnpW = 32 * Prw;

  typedef enum logic {StIdle, StRecall} state_e;

  state_e              state_q, state_d;
  logic [SnpW-1:0]     snap_q [NumCkpt];
  logic [SnpW-1:0]     recall_q;
  logic [NumCkpt-1:0]  valid_q, valid_d;
  logic [NumCkpt-1:0]  done_q, done_d;
  logic [NumCkpt-1:0]  squash_q, squash_d;
  logic [TagW-1:0]     head_q, head_d;
  logic [TagW-1:0]     tail_q, tail_d;
  logic [CntW-1:0]     count_q, count_d;

  logic                full;
  logic                mispredict_now;
  logic                resolve_ok;
  logic                alloc_ok;
  logic                grant;
  logic                retire;
  logic [TagW-1:0]     tag_age;
  logic [NumCkpt-1:0]  younger;
  logic [CntW-1:0]     n_younger;

  assign full           = (count_q == CntW'(NumCkpt));
  assign mispredict_now = res_valid_i & res_mispredict_i & valid_q[res_tag_i];
  assign resolve_ok     = res_valid_i & ~res_mispredict_i & valid_q[res_tag_i];
  assign alloc_ok       = (state_q == StIdle) & ~full & ~ext_stall_i & ~mispredict_now;
  assign grant          = alloc_ok & (|br_valid_i);
  assign retire         = valid_q[head_q] & done_q[head_q];

  // Age is distance from head; live slots occupy ages 0..count-1, so "younger than the
  // mispredicted tag" is simply a larger age among valid slots.
  always_comb begin
    tag_age   = res_tag_i - head_q;
    younger   = '0;
    n_younger = '0;
    for (int unsigned i = 0; i < NumCkpt; i++) begin
      if (valid_q[i] && ((TagW'(i) - head_q) > tag_age)) begin
        younger[i] = 1'b1;
        n_younger  = n_younger + CntW'(1);
      end
    end
  end

  always_comb begin
    state_d  = mispredict_now ? StRecall : StIdle;
    valid_d  = valid_q;
    done_d   = done_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    squash_d = '0;
    if (mispredict_now) begin
      valid_d            = valid_q & ~younger;
      done_d             = done_q & ~younger;
      done_d[res_tag_i]  = 1'b1;
      tail_d             = res_tag_i + TagW'(1);
      squash_d           = younger;
      count_d            = count_q - n_younger;
    end else begin
      if (resolve_ok) begin
        done_d[res_tag_i] = 1'b1;
      end
      if (grant) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        tail_d          = tail_q + TagW'(1);
        count_d         = count_d + CntW'(1);
      end
    end
    // Retire last so a freed head wins over any same-cycle done update to it.
    if (retire) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      head_d          = head_q + TagW'(1);
      count_d         = count_d - CntW'(1);
    end
  end

  always_comb begin
    if_checkpoint_o = 2'b00;
    if (alloc_ok) begin
      if_checkpoint_o = br_valid_i[0] ? 2'b01 : {br_valid_i[1], 1'b0};
    end
    // A mispredict flushes rename, so the bundle is dropped rather than held.
    ckpt_stall_o = ~mispredict_now &
                   ((br_valid_i[0] & br_valid_i[1]) |
                    ((|br_valid_i) & ~alloc_ok & ~ext_stall_i));
  end

  assign ckpt_tag_o     = tail_q;
  assign if_recall_o    = (state_q == StRecall);
  assign recalled_rmt_o = recall_q;
  assign squash_mask_o  = squash_q;
  assign full_o         = full;
  assign free_count_o   = CntW'(NumCkpt) - count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      valid_q  <= '0;
      done_q   <= '0;
      squash_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      recall_q <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      squash_q <= squash_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      if (mispredict_now) begin
        recall_q <= snap_q[res_tag_i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant) begin
      snap_q[tail_q] <= checkpointed_rmt_i;
    end
  end

endmodule

// File: tb/tb_rmt_checkpoint_manager.sv
// Bench for rmt_checkpoint_manager: directed scenarios plus a queue-based model of the live
// checkpoint list, compared against the DUT on every cycle.
module tb_rmt_checkpoint_manager;

  localparam int RW = 32 * 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ext_stall = 1'b0;
  logic [1:0]    br_valid = '0;
  logic [1:0]    if_checkpoint;
  logic [1:0]    ckpt_tag;
  logic          ckpt_stall;
  logic [RW-1:0] ckpt_rmt = '0;
  logic          res_valid = 1'b0;
  logic [1:0]    res_tag = '0;
  logic          res_mispredict = 1'b0;
  logic          if_recall;
  logic [RW-1:0] recalled_rmt;
  logic [3:0]    squash_mask;
  logic          full;
  logic [2:0]    free_count;

  int n_cmp = 0;
  int n_bad = 0;
  int seed_ctr = 1;

  rmt_checkpoint_manager #(.NumPr(64), .NumCkpt(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .ext_stall_i        (ext_stall),
    .br_valid_i         (br_valid),
    .if_checkpoint_o    (if_checkpoint),
    .ckpt_tag_o         (ckpt_tag),
    .ckpt_stall_o       (ckpt_stall),
    .checkpointed_rmt_i (ckpt_rmt),
    .res_valid_i        (res_valid),
    .res_tag_i          (res_tag),
    .res_mispredict_i   (res_mispredict),
    .if_recall_o        (if_recall),
    .recalled_rmt_o     (recalled_rmt),
    .squash_mask_o      (squash_mask),
    .full_o             (full),
    .free_count_o       (free_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] mk_rmt(input int seed);
    logic [RW-1:0] v;
    for (int r = 0; r < 32; r++) v[r*6 +: 6] = 6'((seed * 5 + r * 3) % 64);
    return v;
  endfunction

  // Model: live checkpoints kept oldest-first as a queue of tags.
  int            m_live[$];
  bit            m_done[4];
  logic [RW-1:0] m_snap[4];
  int            m_tail = 0;
  bit            m_recall = 1'b0;
  logic [RW-1:0] m_rv = '0;
  logic [3:0]    m_squash = '0;
  bit            e_misp, e_alloc, e_stall;
  logic [1:0]    e_ifck;
  int            e_pos;

  task automatic model_eval();
    e_pos = -1;
    foreach (m_live[j]) if (m_live[j] == int'(res_tag)) e_pos = j;
    e_misp  = res_valid && res_mispredict && (e_pos >= 0);
    e_alloc = !m_recall && (m_live.size() < 4) && !ext_stall && !e_misp;
    e_ifck  = !e_alloc ? 2'b00 : br_valid[0] ? 2'b01 : br_valid[1] ? 2'b10 : 2'b00;
    if (e_misp) e_stall = 1'b0;
    else if (br_valid == 2'b11) e_stall = 1'b1;
    else e_stall = (br_valid != 2'b00) && !e_alloc && !ext_stall;
  endtask

  task automatic model_edge();
    bit retire;
    int t;
    if (reset) begin
      m_live.delete();
      m_tail = 0;
      m_recall = 1'b0;
      m_squash = '0;
      for (int j = 0; j < 4; j++) m_done[j] = 1'b0;
      return;
    end
    model_eval();
    retire = (m_live.size() > 0) && m_done[m_live[0]];
    m_squash = '0;
    if (e_misp) begin
      while (m_live.size() > e_pos + 1) begin
        t = m_live.pop_back();
        m_squash[t] = 1'b1;
      end
      m_done[res_tag] = 1'b1;
      m_recall = 1'b1;
      m_rv = m_snap[res_tag];
      m_tail = (int'(res_tag) + 1) % 4;
    end else begin
      m_recall = 1'b0;
      if (res_valid && e_pos >= 0) m_done[res_tag] = 1'b1;
      if (e_ifck != 2'b00) begin
        m_snap[m_tail] = ckpt_rmt;
        m_done[m_tail] = 1'b0;
        m_live.push_back(m_tail);
        m_tail = (m_tail + 1) % 4;
      end
    end
    if (retire) void'(m_live.pop_front());
  endtask

  always begin
    @(negedge clk);
    #2;
    model_eval();
    check("if_checkpoint", RW'(if_checkpoint), RW'(e_ifck));
    check("ckpt_tag", RW'(ckpt_tag), RW'(m_tail));
    check("ckpt_stall", RW'(ckpt_stall), RW'(e_stall));
    check("if_recall", RW'(if_recall), RW'(m_recall));
    if (m_recall) check("recalled_rmt", recalled_rmt, m_rv);
    check("squash_mask", RW'(squash_mask), RW'(m_squash));
    check("full", RW'(full), RW'(m_live.size() == 4));
    check("free_count", RW'(free_count), RW'(4 - m_live.size()));
    @(posedge clk);
    model_edge();
  end

  task automatic drive(input logic rst, input logic [1:0] br, input logic ext,
                       input logic rv, input logic [1:0] rt, input logic rm);
    @(negedge clk);
    reset = rst;
    br_valid = br;
    ext_stall = ext;
    res_valid = rv;
    res_tag = rt;
    res_mispredict = rm;
    ckpt_rmt = mk_rmt(seed_ctr);
    seed_ctr++;
  endtask

  task automatic go(input logic [1:0] br);
    drive(1'b0, br, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic res(input logic [1:0] tag, input logic mis, input logic [1:0] br);
    drive(1'b0, br, 1'b0, 1'b1, tag, mis);
  endtask

  task automatic do_reset();
    drive(1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    // 1: reset state, fill to full, fifth branch stalls
    do_reset();
    #2;
    check("rst_free", RW'(free_count), RW'(4));
    check("rst_full", RW'(full), RW'(0));
    check("rst_recall", RW'(if_recall), RW'(0));
    check("rst_squash", RW'(squash_mask), RW'(0));
    for (int i = 0; i < 4; i++) begin
      go(2'b01);
      #2;
      check("t1_tag", RW'(ckpt_tag), RW'(i));
      check("t1_ifck", RW'(if_checkpoint), RW'(2'b01));
    end
    go(2'b01);
    #2;
    check("t1_full", RW'(full), RW'(1));
    check("t1_stall", RW'(ckpt_stall), RW'(1));
    check("t1_nogrant", RW'(if_checkpoint), RW'(0));

    // 2: two branches, lane 0 then lane 1
    do_reset();
    go(2'b11);
    #2;
    check("t2_ifck0", RW'(if_checkpoint), RW'(2'b01));
    check("t2_tag0", RW'(ckpt_tag), RW'(0));
    check("t2_stall0", RW'(ckpt_stall), RW'(1));
    go(2'b10);
    #2;
    check("t2_ifck1", RW'(if_checkpoint), RW'(2'b10));
    check("t2_tag1", RW'(ckpt_tag), RW'(1));
    check("t2_stall1", RW'(ckpt_stall), RW'(0));

    // 3: out-of-order correct resolves drain in order
    do_reset();
    for (int i = 0; i < 4; i++) go(2'b01);
    res(2'd2, 1'b0, 2'b00);
    res(2'd1, 1'b0, 2'b00);
    res(2'd0, 1'b0, 2'b00);
    go(2'b00);
    #2;
    check("t3_free_i1", RW'(free_count), RW'(0));
    go(2'b00);
    #2;
    check("t3_free_i2", RW'(free_count), RW'(1));
    go(2'b00);
    #2;
    check("t3_free_i3", RW'(free_count), RW'(2));
    go(2'b00);
    #2;
    check("t3_free_i4", RW'(free_count), RW'(3));
    go(2'b00);
    #2;
    check("t3_free_i5", RW'(free_count), RW'(3));

    // 4: mispredict oldest, recall its snapshot, squash younger
    do_reset();
    go(2'b01);
    ckpt_rmt[5*6 +: 6] = 6'd40;
    go(2'b01);
    go(2'b01);
    res(2'd0, 1'b1, 2'b00);
    go(2'b01);
    #2;
    check("t4_recall", RW'(if_recall), RW'(1));
    check("t4_rmt5", RW'(recalled_rmt[5*6 +: 6]), RW'(40));
    check("t4_squash", RW'(squash_mask), RW'(4'b0110));
    check("t4_nogrant", RW'(if_checkpoint), RW'(0));
    check("t4_stall", RW'(ckpt_stall), RW'(1));
    check("t4_free", RW'(free_count), RW'(3));
    go(2'b01);
    #2;
    check("t4_tag", RW'(ckpt_tag), RW'(1));
    check("t4_ifck", RW'(if_checkpoint), RW'(2'b01));

    // 5: wrapped pointers, mispredict with a branch present
    do_reset();
    for (int i = 0; i < 3; i++) go(2'b01);
    res(2'd0, 1'b0, 2'b00);
    res(2'd1, 1'b0, 2'b00);
    res(2'd2, 1'b0, 2'b00);
    go(2'b00);
    go(2'b01);
    #2;
    check("t5_tag3", RW'(ckpt_tag), RW'(3));
    go(2'b01);
    #2;
    check("t5_tag0", RW'(ckpt_tag), RW'(0));
    res(2'd3, 1'b1, 2'b01);
    #2;
    check("t5_nogrant", RW'(if_checkpoint), RW'(0));
    check("t5_nostall", RW'(ckpt_stall), RW'(0));
    go(2'b00);
    #2;
    check("t5_squash", RW'(squash_mask), RW'(4'b0001));
    check("t5_recall", RW'(if_recall), RW'(1));
    go(2'b00);
    #2;
    check("t5_tail", RW'(ckpt_tag), RW'(0));
    check("t5_free", RW'(free_count), RW'(4));

    // 6: reset during recall
    do_reset();
    go(2'b01);
    go(2'b01);
    res(2'd0, 1'b1, 2'b00);
    drive(1'b1, 2'b00, 1'b0, 1'b0, 2'd0, 1'b0);
    #2;
    check("t6_inrecall", RW'(if_recall), RW'(1));
    go(2'b00);
    #2;
    check("t6_recall", RW'(if_recall), RW'(0));
    check("t6_free", RW'(free_count), RW'(4));
    check("t6_squash", RW'(squash_mask), RW'(0));

    // 7: nested mispredict, invalid-tag resolve, ext_stall, resolve alongside grant
    do_reset();
    for (int i = 0; i < 4; i++) go(2'b01);
    res(2'd2, 1'b1, 2'b00);
    res(2'd1, 1'b1, 2'b00);
    #2;
    check("t7_squash1", RW'(squash_mask), RW'(4'b1000));
    go(2'b00);
    #2;
    check("t7_squash2", RW'(squash_mask), RW'(4'b0100));
    check("t7_recall2", RW'(if_recall), RW'(1));
    res(2'd3, 1'b1, 2'b00);
    drive(1'b0, 2'b01, 1'b1, 1'b0, 2'd0, 1'b0);
    #2;
    check("t7_ext_stall", RW'(ckpt_stall), RW'(0));
    check("t7_ext_nogrant", RW'(if_checkpoint), RW'(0));
    res(2'd0, 1'b0, 2'b01);
    for (int i = 0; i < 6; i++) go(2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
